// File: rtl/mesh_term_fifo_pkg.sv
// ---------------------------------------------------------------------------
// mesh_term_pkg
// Shared constants and sizing helpers for the mesh terminal FIFO.
//   PCKG_SZ_DEF : default packet width in bits
//   DROP_W      : width of the saturating drop counter
//   cnt_w()     : width needed to hold an occupancy of 0..depth
//   ptr_w()     : width needed to address 0..depth-1
// ---------------------------------------------------------------------------
package mesh_term_pkg;

    localparam int PCKG_SZ_DEF = 50;
    localparam int DROP_W      = 16;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Depth is at least 2, so this never collapses to zero bits.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mesh_term_fifo_if.sv
// ---------------------------------------------------------------------------
// mesh_term_fifo_if
// Handshake bundle between a mesh terminal / router and its terminal FIFO.
//   push, data_in, full          : terminal write side
//   pop, data_out, pndng         : router read side (first-word-fall-through)
//   flush                        : synchronous discard of all stored packets
//   count, drop_cnt              : occupancy and saturating drop statistics
// Modports:
//   master : the driver of the FIFO (terminal + router side)
//   slave  : the FIFO itself
// ---------------------------------------------------------------------------
interface mesh_term_fifo_if
    import mesh_term_pkg::*;
#(
    parameter int pckg_sz    = PCKG_SZ_DEF,
    parameter int fifo_depth = 4
);

    localparam int CNT_W = cnt_w(fifo_depth);

    logic               push;
    logic [pckg_sz-1:0] data_in;
    logic               full;
    logic               pop;
    logic [pckg_sz-1:0] data_out;
    logic               pndng;
    logic               flush;
    logic [CNT_W-1:0]   count;
    logic [DROP_W-1:0]  drop_cnt;

    modport master (
        output push, data_in, pop, flush,
        input  full, data_out, pndng, count, drop_cnt
    );

    modport slave (
        input  push, data_in, pop, flush,
        output full, data_out, pndng, count, drop_cnt
    );

endinterface

// File: rtl/mesh_term_fifo.sv
// ---------------------------------------------------------------------------
// mesh_term_fifo
// First-word-fall-through packet FIFO sitting between one mesh terminal and
// the router. The head packet is visible on data_out whenever pndng=1.
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   reset : asynchronous active-low reset (clears pointers, count, drop_cnt)
//   bus   : mesh_term_fifo_if.slave (push/data_in/full, pop/data_out/pndng,
//           flush, count, drop_cnt)
// ---------------------------------------------------------------------------
module mesh_term_fifo
    import mesh_term_pkg::*;
#(
    parameter int pckg_sz    = PCKG_SZ_DEF,
    parameter int fifo_depth = 4
) (
    input logic              clk,
    input logic              reset,
    mesh_term_fifo_if.slave  bus
);

    localparam int CNT_W = cnt_w(fifo_depth);
    localparam int PTR_W = ptr_w(fifo_depth);

    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(fifo_depth);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(fifo_depth - 1);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic [pckg_sz-1:0] mem [fifo_depth];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [DROP_W-1:0] drop_cnt;

    logic full;
    logic pndng;
    logic do_pop;
    logic do_push;
    logic drop;

    // Pointers wrap explicitly so depths that are not a power of two work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Status flags depend only on the registered count.
    assign full  = (count == DEPTH_C);
    assign pndng = (count != '0);

    // A pop on an empty FIFO is ignored. A push into a full FIFO still goes
    // through if the same-cycle pop frees the head slot.
    assign do_pop  = bus.pop && pndng;
    assign do_push = bus.push && (!full || do_pop);
    assign drop    = bus.push && full && !bus.pop;

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Packet storage is deliberately not reset; only the pointers define
    // which entries are live.
    always_ff @(posedge clk) begin
        if (!bus.flush && do_push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointer and occupancy state. Flush takes priority over push and pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_nxt;
        end
    end

    // Rejected pushes are counted until the counter saturates; a flush
    // cycle discards the push instead of counting it as a drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (drop && !bus.flush && (drop_cnt != DROP_MAX)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign bus.data_out = mem[rd_ptr];
    assign bus.full     = full;
    assign bus.pndng    = pndng;
    assign bus.count    = count;
    assign bus.drop_cnt = drop_cnt;

endmodule

// File: tb/tb_mesh_term_fifo.sv
// ---------------------------------------------------------------------------
// tb_mesh_term_fifo
// Self-checking bench for mesh_term_fifo (pckg_sz=50, fifo_depth=4).
// Directed vector table, hand-written corner sequences and randomized
// traffic, all compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_mesh_term_fifo;

    localparam int PW    = 50;
    localparam int DEPTH = 4;

    typedef struct {
        bit            push;
        logic [PW-1:0] din;
        bit            pop;
        bit            flush;
        int            ecount;
        bit            epndng;
        bit            efull;
        logic [PW-1:0] edata;
    } vec_t;

    logic clk;
    logic reset;

    int n_assert;
    int n_fail;

    logic [PW-1:0] model_q[$];
    int            model_drops;

    mesh_term_fifo_if #(.pckg_sz(PW), .fifo_depth(DEPTH)) bus ();

    mesh_term_fifo #(.pckg_sz(PW), .fifo_depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure on mismatch.
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue with the FIFO's acceptance rules.
    task automatic modelStep(input bit p, input logic [PW-1:0] d, input bit po, input bit fl);
        bit was_full;
        bit had;
        if (fl) begin
            model_q.delete();
        end else begin
            was_full = (model_q.size() == DEPTH);
            had      = (model_q.size() != 0);
            if (po && had) void'(model_q.pop_front());
            if (p) begin
                if (!was_full || po) model_q.push_back(d);
                else if (model_drops < 65535) model_drops++;
            end
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_drops = 0;
    endtask

    // Drive one cycle of inputs, let the edge happen, then sample at +1.
    task automatic applyStimulus(input bit p, input logic [PW-1:0] d, input bit po, input bit fl);
        bus.push    = p;
        bus.data_in = d;
        bus.pop     = po;
        bus.flush   = fl;
        @(posedge clk);
        modelStep(p, d, po, fl);
        #1;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.flush = 1'b0;
    endtask

    // Compare every visible output against the reference model.
    task automatic checkOutput(input string tag);
        check({tag, ".count"}, 64'(bus.count), 64'(model_q.size()));
        check({tag, ".pndng"}, 64'(bus.pndng), 64'(model_q.size() != 0));
        check({tag, ".full"}, 64'(bus.full), 64'(model_q.size() == DEPTH));
        check({tag, ".drop_cnt"}, 64'(bus.drop_cnt), 64'(model_drops));
        if (model_q.size() != 0) check({tag, ".data_out"}, 64'(bus.data_out), 64'(model_q[0]));
    endtask

    function automatic logic [PW-1:0] rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[PW-1:0];
    endfunction

    initial begin
        vec_t          vec[11];
        logic [PW-1:0] pa, pb, pc, pd, pe, pf, px, py;

        n_assert = 0;
        n_fail   = 0;
        modelReset();

        pa = 50'h2_AAAA_0000_0001;
        pb = 50'h1_BBBB_0000_0002;
        pc = 50'h3_CCCC_0000_0003;
        pd = 50'h0_DDDD_0000_0004;
        pe = 50'h2_EEEE_0000_0005;
        pf = 50'h1_FFFF_0000_0006;
        px = 50'h3_1234_5678_9ABC;
        py = 50'h0_5A5A_A5A5_0F0F;

        vec[0]  = '{1, pa, 0, 0, 1, 1, 0, pa};
        vec[1]  = '{1, pb, 0, 0, 2, 1, 0, pa};
        vec[2]  = '{1, pc, 0, 0, 3, 1, 0, pa};
        vec[3]  = '{1, pd, 0, 0, 4, 1, 1, pa};
        vec[4]  = '{0, '0, 1, 0, 3, 1, 0, pb};
        vec[5]  = '{0, '0, 1, 0, 2, 1, 0, pc};
        vec[6]  = '{0, '0, 1, 0, 1, 1, 0, pd};
        vec[7]  = '{0, '0, 1, 0, 0, 0, 0, '0};
        vec[8]  = '{1, px, 1, 0, 1, 1, 0, px};
        vec[9]  = '{0, '0, 1, 0, 0, 0, 0, '0};
        vec[10] = '{0, '0, 1, 0, 0, 0, 0, '0};

        // Asynchronous reset state, before any clock edge.
        reset       = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.flush   = 1'b0;
        bus.data_in = '0;
        #1;
        check("reset.count", 64'(bus.count), 64'd0);
        check("reset.pndng", 64'(bus.pndng), 64'd0);
        check("reset.full", 64'(bus.full), 64'd0);
        check("reset.drop_cnt", 64'(bus.drop_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table: fill to full, drain in order, push+pop when empty.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vec[i].push, vec[i].din, vec[i].pop, vec[i].flush);
            check($sformatf("vec%0d.count", i), 64'(bus.count), 64'(vec[i].ecount));
            check($sformatf("vec%0d.pndng", i), 64'(bus.pndng), 64'(vec[i].epndng));
            check($sformatf("vec%0d.full", i), 64'(bus.full), 64'(vec[i].efull));
            if (vec[i].epndng) check($sformatf("vec%0d.data", i), 64'(bus.data_out), 64'(vec[i].edata));
            checkOutput($sformatf("vec%0d.model", i));
        end

        // Full FIFO: plain push is dropped, push with pop is accepted.
        applyStimulus(1, pa, 0, 0);
        applyStimulus(1, pb, 0, 0);
        applyStimulus(1, pc, 0, 0);
        applyStimulus(1, pd, 0, 0);
        check("fill.full", 64'(bus.full), 64'd1);
        applyStimulus(1, pe, 0, 0);
        check("dropE.drop_cnt", 64'(bus.drop_cnt), 64'd1);
        check("dropE.count", 64'(bus.count), 64'd4);
        check("dropE.head", 64'(bus.data_out), 64'(pa));
        applyStimulus(1, pf, 1, 0);
        check("pushF.count", 64'(bus.count), 64'd4);
        check("pushF.head", 64'(bus.data_out), 64'(pb));
        check("drainF.d0", 64'(bus.data_out), 64'(pb));
        applyStimulus(0, '0, 1, 0);
        check("drainF.d1", 64'(bus.data_out), 64'(pc));
        applyStimulus(0, '0, 1, 0);
        check("drainF.d2", 64'(bus.data_out), 64'(pd));
        applyStimulus(0, '0, 1, 0);
        check("drainF.last", 64'(bus.data_out), 64'(pf));
        applyStimulus(0, '0, 1, 0);
        check("drainF.pndng", 64'(bus.pndng), 64'd0);
        checkOutput("drainF");

        // Flush overrides simultaneous push and pop.
        applyStimulus(1, pa, 0, 0);
        applyStimulus(1, pb, 0, 0);
        check("preflush.count", 64'(bus.count), 64'd2);
        applyStimulus(1, pc, 1, 1);
        check("flush.count", 64'(bus.count), 64'd0);
        check("flush.pndng", 64'(bus.pndng), 64'd0);
        applyStimulus(0, '0, 0, 0);
        check("postflush.count", 64'(bus.count), 64'd0);
        check("postflush.drop_cnt", 64'(bus.drop_cnt), 64'd1);

        // Reset mid-operation clears state without a clock edge.
        applyStimulus(1, pa, 0, 0);
        applyStimulus(1, pb, 0, 0);
        applyStimulus(1, pc, 0, 0);
        check("prereset.count", 64'(bus.count), 64'd3);
        #1 reset = 1'b0;
        #1;
        modelReset();
        check("midreset.pndng", 64'(bus.pndng), 64'd0);
        check("midreset.count", 64'(bus.count), 64'd0);
        check("midreset.drop_cnt", 64'(bus.drop_cnt), 64'd0);
        check("midreset.full", 64'(bus.full), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1, py, 0, 0);
        check("firstpush.count", 64'(bus.count), 64'd1);
        check("firstpush.data", 64'(bus.data_out), 64'(py));
        applyStimulus(0, '0, 1, 0);
        checkOutput("firstpush.pop");

        // Fill/drain rounds of three so both pointers wrap repeatedly.
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) begin
                applyStimulus(1, rnd(), 0, 0);
                checkOutput($sformatf("wrap%0d.push%0d", r, k));
            end
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("wrap%0d.head%0d", r, k));
                applyStimulus(0, '0, 1, 0);
            end
            check($sformatf("wrap%0d.empty", r), 64'(bus.pndng), 64'd0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 31) == 0));
            checkOutput($sformatf("rand%0d", c));
        end

        // Drop counter saturation.
        #1 reset = 1'b0;
        #1 modelReset();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < DEPTH; k++) applyStimulus(1, rnd(), 0, 0);
        for (int k = 0; k < 65534; k++) applyStimulus(1, rnd(), 0, 0);
        check("sat.below", 64'(bus.drop_cnt), 64'd65534);
        applyStimulus(1, rnd(), 0, 0);
        check("sat.reach", 64'(bus.drop_cnt), 64'd65535);
        for (int k = 0; k < 4465; k++) applyStimulus(1, rnd(), 0, 0);
        check("sat.hold", 64'(bus.drop_cnt), 64'hFFFF);
        checkOutput("sat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mesh_term_fifo.md
MESH_TERM_FIFO -- requirements
Module: mesh_term_fifo

Interface
REQ-001 The block SHALL have parameter pckg_sz, default 50, packet width in bits.
REQ-002 The block SHALL have parameter fifo_depth, default 4, packet storage entries (>=2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL be updated on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port push, input, 1, terminal requests write of data_in.
REQ-006 The block SHALL have port data_in, input, pckg_sz, packet from the terminal.
REQ-007 The block SHALL have port full, output, 1, storage holds fifo_depth packets.
REQ-008 The block SHALL have port pop, input, 1, mesh router consumes the head packet.
REQ-009 The block SHALL have port data_out, output, pckg_sz, head packet, valid while pndng=1.
REQ-010 The block SHALL have port pndng, output, 1, at least one packet stored; this drives the router's per-terminal pending input.
REQ-011 The block SHALL have port flush, input, 1, synchronous discard of all stored packets.
REQ-012 The block SHALL have port count, output, CNT_W = clog2(fifo_depth+1), packets stored.
REQ-013 The block SHALL have port drop_cnt, output, 16, packets rejected because storage was full.

Function
REQ-014 The block SHALL be first-word-fall-through: data_out SHALL equal the oldest stored packet combinationally from storage, with no read latency.
REQ-015 A packet pushed into an empty FIFO SHALL appear on data_out with pndng=1 in the cycle after the push edge (1-cycle latency).
REQ-016 A push with full=0 SHALL store data_in at the write pointer, advance the write pointer, and increment count.
REQ-017 A pop with pndng=1 SHALL advance the read pointer and decrement count.
REQ-018 A pop with pndng=0 SHALL be ignored, with no pointer or count change.
REQ-019 Simultaneous push and pop with 0<count<fifo_depth SHALL leave count unchanged and perform both operations.
REQ-020 Simultaneous push and pop with count=fifo_depth SHALL accept the push: pop frees the head and the new packet is written.
REQ-021 Simultaneous push and pop with count=0 SHALL store the push only; the pop is ignored.
REQ-022 A push with full=1 and pop=0 SHALL be dropped, leave storage unchanged, and increment drop_cnt, saturating at 16'hFFFF.
REQ-023 Read and write pointers SHALL wrap from fifo_depth-1 to 0; fifo_depth need not be a power of two.
REQ-024 full SHALL be 1 exactly when count=fifo_depth, and pndng SHALL be 1 exactly when count!=0; both SHALL be registered-derived, with no combinational path from push or pop.
REQ-025 flush=1 SHALL zero both pointers and count at the next edge and SHALL override push and pop in the same cycle; drop_cnt SHALL be unaffected.
REQ-026 data_out SHALL be don't-care while pndng=0; the bench SHALL NOT check it then.

Reset
REQ-027 Asserting reset low SHALL immediately clear the pointers, count, and drop_cnt, forcing pndng=0, full=0, count=0, and drop_cnt=0 without waiting for clk.
REQ-028 Storage contents SHALL NOT be reset.
REQ-029 Deassertion SHALL be synchronised externally, and the first push SHALL be accepted on the first edge after deassertion.
REQ-030 When reset asserts mid-operation, all stored packets SHALL be lost, and pndng SHALL be 0 within the same cycle, so it is low well inside the mesh 4-cycle post-reset pending window.

Structure
REQ-031 The shared package mesh_term_pkg SHALL hold CNT_W as a function of fifo_depth, the drop_cnt width constant (16), and the pckg_sz default.
REQ-032 No sub-module is required; storage SHALL be an internal register array of fifo_depth x pckg_sz.
REQ-033 Sixteen instances, one per mesh terminal, SHALL feed the router's pndng_i_in and data_out_i_in and take its pop.

Verification
REQ-034 The bench (pckg_sz=50, fifo_depth=4) SHALL cover: reset low while count=3 -> pndng=0 and count=0 in the same cycle, drop_cnt=0.
REQ-035 The bench SHALL cover: push A,B,C,D on consecutive cycles -> full=1 after the 4th edge; pops return A,B,C,D in order; pndng=0 after the 4th pop.
REQ-036 The bench SHALL cover: with full=1, push E without pop -> E dropped, drop_cnt=1; then push F with pop -> count stays 4 and the last packet popped is F.
REQ-037 The bench SHALL cover: with count=0, push X and pop in the same cycle -> count=1 and data_out=X next cycle.
REQ-038 The bench SHALL cover: with count=2, flush, push, and pop in the same cycle -> count=0, pndng=0, and the pushed packet is discarded.
REQ-039 The bench SHALL cover: 10 fill/drain rounds of 3 packets each -> pointers wrap and data stays in order; 70000 pushes while full -> drop_cnt saturates at 65535.
